// File: rtl/id_ex_forward_reg_pkg.sv
// rtl/id_ex_forward_reg_pkg.sv - shared widths and operand-mux select encodings
package id_ex_forward_reg_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

endpackage

// File: rtl/id_ex_forward_reg_forward_select.sv
// rtl/id_ex_forward_reg_forward_select.sv - per-source forwarding compare and priority
module forward_select
  import id_ex_forward_reg_pkg::*;
#(
  parameter int AW = id_ex_forward_reg_pkg::REG_AW
) (
  input  logic          i_valid,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic          i_exmem_we,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic          i_memwb_we,
  output logic [1:0]    o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // r0 is hardwired zero, so a write to it never produces a forwardable value
  assign w_exmem_hit = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
  assign w_memwb_hit = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

  always_comb begin
    o_sel = SEL_REG;
    if (i_valid) begin
      if (w_exmem_hit)      o_sel = SEL_EXMEM;
      else if (w_memwb_hit) o_sel = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_forward_reg.sv
// rtl/id_ex_forward_reg.sv - ID/EX pipeline register with forwarding select generation
module id_ex_forward_reg
  import id_ex_forward_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = id_ex_forward_reg_pkg::REG_AW
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] ID_Rd,
  input  logic              ID_RegWrite,
  input  logic              ID_Valid,
  input  logic [REG_AW-1:0] EXMEM_Rd,
  input  logic [REG_AW-1:0] MEMWB_Rd,
  input  logic              EXMEM_RegWrite,
  input  logic              MEMWB_RegWrite,
  input  logic [DATA_W-1:0] MEMWB_Data,
  output logic [DATA_W-1:0] EX_RsData,
  output logic [DATA_W-1:0] EX_RtData,
  output logic [REG_AW-1:0] EX_Rs,
  output logic [REG_AW-1:0] EX_Rt,
  output logic [REG_AW-1:0] EX_Rd,
  output logic              EX_RegWrite,
  output logic              EX_Valid,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB
);

  logic [DATA_W-1:0] r_rs_data, r_rt_data;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic              r_reg_write, r_valid;
  logic              w_rs_wb_hit, w_rt_wb_hit;

  // While stalled, a value retiring from MEM/WB would otherwise be lost to the held operand
  assign w_rs_wb_hit = MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == r_rs);
  assign w_rt_wb_hit = MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == r_rt);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_valid     <= 1'b0;
    end else if (Flush) begin
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_valid     <= 1'b0;
    end else if (!Stall) begin
      r_rs_data   <= ID_RsData;
      r_rt_data   <= ID_RtData;
      r_rs        <= ID_Rs;
      r_rt        <= ID_Rt;
      r_rd        <= ID_Rd;
      r_reg_write <= ID_RegWrite;
      r_valid     <= ID_Valid;
    end else begin
      if (w_rs_wb_hit) r_rs_data <= MEMWB_Data;
      if (w_rt_wb_hit) r_rt_data <= MEMWB_Data;
    end
  end

  assign EX_RsData   = r_rs_data;
  assign EX_RtData   = r_rt_data;
  assign EX_Rs       = r_rs;
  assign EX_Rt       = r_rt;
  assign EX_Rd       = r_rd;
  assign EX_RegWrite = r_reg_write;
  assign EX_Valid    = r_valid;

  forward_select #(.AW(REG_AW)) u_fwd_a (
    .i_valid    (r_valid),
    .i_src      (r_rs),
    .i_exmem_rd (EXMEM_Rd),
    .i_exmem_we (EXMEM_RegWrite),
    .i_memwb_rd (MEMWB_Rd),
    .i_memwb_we (MEMWB_RegWrite),
    .o_sel      (ForwardA)
  );

  forward_select #(.AW(REG_AW)) u_fwd_b (
    .i_valid    (r_valid),
    .i_src      (r_rt),
    .i_exmem_rd (EXMEM_Rd),
    .i_exmem_we (EXMEM_RegWrite),
    .i_memwb_rd (MEMWB_Rd),
    .i_memwb_we (MEMWB_RegWrite),
    .o_sel      (ForwardB)
  );

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// tb/tb_id_ex_forward_reg.sv - directed and randomized bench for id_ex_forward_reg
module tb_id_ex_forward_reg;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst, Stall, Flush;
  logic [DW-1:0] ID_RsData, ID_RtData, MEMWB_Data;
  logic [AW-1:0] ID_Rs, ID_Rt, ID_Rd, EXMEM_Rd, MEMWB_Rd;
  logic          ID_RegWrite, ID_Valid, EXMEM_RegWrite, MEMWB_RegWrite;
  logic [DW-1:0] EX_RsData, EX_RtData;
  logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd;
  logic          EX_RegWrite, EX_Valid;
  logic [1:0]    ForwardA, ForwardB;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          valid;
    bit          we;
    int unsigned rs, rt, rd;
    int unsigned rsd, rtd;
  } stage_t;

  stage_t m;

  id_ex_forward_reg #(.DATA_W(DW), .REG_AW(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_RegWrite(ID_RegWrite), .ID_Valid(ID_Valid),
    .EXMEM_Rd(EXMEM_Rd), .MEMWB_Rd(MEMWB_Rd),
    .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
    .MEMWB_Data(MEMWB_Data),
    .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_Valid(EX_Valid),
    .ForwardA(ForwardA), .ForwardB(ForwardB)
  );

  always #5 Clk = ~Clk;

  function automatic stage_t bubble();
    stage_t s;
    s.valid = 0; s.we = 0; s.rs = 0; s.rt = 0; s.rd = 0; s.rsd = 0; s.rtd = 0;
    return s;
  endfunction

  // Next EX contents given the current stage and the inputs present at the edge
  function automatic stage_t next_stage(stage_t s);
    stage_t n = s;
    if (Flush) n = bubble();
    else if (!Stall) begin
      n.valid = ID_Valid; n.we = ID_RegWrite;
      n.rs = ID_Rs; n.rt = ID_Rt; n.rd = ID_Rd;
      n.rsd = ID_RsData; n.rtd = ID_RtData;
    end else if (MEMWB_RegWrite) begin
      if (MEMWB_Rd != 0 && MEMWB_Rd == s.rs) n.rsd = MEMWB_Data;
      if (MEMWB_Rd != 0 && MEMWB_Rd == s.rt) n.rtd = MEMWB_Data;
    end
    return n;
  endfunction

  function automatic int unsigned fwd(stage_t s, int unsigned src);
    if (!s.valid) return 0;
    if (EXMEM_RegWrite && EXMEM_Rd != 0 && EXMEM_Rd == src) return 1;
    if (MEMWB_RegWrite && MEMWB_Rd != 0 && MEMWB_Rd == src) return 2;
    return 0;
  endfunction

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ":EX_Valid"},    32'(EX_Valid),    32'(m.valid));
    chk({tag, ":EX_RegWrite"}, 32'(EX_RegWrite), 32'(m.we));
    chk({tag, ":EX_Rs"},       32'(EX_Rs),       m.rs);
    chk({tag, ":EX_Rt"},       32'(EX_Rt),       m.rt);
    chk({tag, ":EX_Rd"},       32'(EX_Rd),       m.rd);
    chk({tag, ":EX_RsData"},   EX_RsData,        m.rsd);
    chk({tag, ":EX_RtData"},   EX_RtData,        m.rtd);
    chk({tag, ":ForwardA"},    32'(ForwardA),    fwd(m, m.rs));
    chk({tag, ":ForwardB"},    32'(ForwardB),    fwd(m, m.rt));
  endtask

  task automatic tick();
    stage_t n = next_stage(m);
    @(posedge Clk);
    m = n;
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; Flush = 0;
    ID_RsData = 0; ID_RtData = 0; ID_Rs = 0; ID_Rt = 0; ID_Rd = 0;
    ID_RegWrite = 0; ID_Valid = 0;
    EXMEM_Rd = 0; MEMWB_Rd = 0; EXMEM_RegWrite = 0; MEMWB_RegWrite = 0;
    MEMWB_Data = 0;
  endtask

  task automatic load(int unsigned rs, int unsigned rt, int unsigned rsd, int unsigned rtd);
    ID_Valid = 1; ID_RegWrite = 1; ID_Rd = 5'd9;
    ID_Rs = AW'(rs); ID_Rt = AW'(rt); ID_RsData = rsd; ID_RtData = rtd;
    tick();
  endtask

  initial begin
    idle_inputs();
    Rst = 1;
    m = bubble();
    #2;
    chk_all("reset");
    @(negedge Clk);
    Rst = 0;

    // Plain capture: one cycle of latency, no forwarding
    load(3, 6, 32'h11, 32'h66);
    chk_all("capture");
    chk("capture_rs", 32'(EX_Rs), 3);
    chk("capture_rsd", EX_RsData, 32'h11);
    chk("capture_fa", 32'(ForwardA), 0);

    // EX/MEM beats MEM/WB, then MEM/WB alone
    load(4, 0, 32'h44, 32'h0);
    EXMEM_Rd = 4; MEMWB_Rd = 4; EXMEM_RegWrite = 1; MEMWB_RegWrite = 1;
    #1;
    chk("prio_exmem", 32'(ForwardA), 1);
    EXMEM_RegWrite = 0;
    #1;
    chk("memwb_only", 32'(ForwardA), 2);

    // Address zero never forwards
    EXMEM_Rd = 0; EXMEM_RegWrite = 1; MEMWB_RegWrite = 0;
    #1;
    chk("r0_no_fwd", 32'(ForwardB), 0);
    chk_all("r0");
    EXMEM_RegWrite = 0;

    // Three-cycle stall with a writeback landing in cycle 2
    load(7, 2, 32'h77, 32'h22);
    ID_Rs = 1; ID_RsData = 32'h1234; Stall = 1;
    tick();
    chk_all("stall_c1");
    MEMWB_Rd = 7; MEMWB_Data = 32'hDEAD; MEMWB_RegWrite = 1;
    tick();
    chk("stall_c2_rsd", EX_RsData, 32'hDEAD);
    chk("stall_c2_rtd", EX_RtData, 32'h22);
    chk("stall_c2_rs", 32'(EX_Rs), 7);
    MEMWB_RegWrite = 0; MEMWB_Data = 32'hBEEF;
    tick();
    chk_all("stall_c3");
    chk("stall_c3_rsd", EX_RsData, 32'hDEAD);

    // Flush wins over a simultaneous stall
    Flush = 1;
    tick();
    chk("flush_valid", 32'(EX_Valid), 0);
    chk("flush_we", 32'(EX_RegWrite), 0);
    chk("flush_fa", 32'(ForwardA), 0);
    chk("flush_fb", 32'(ForwardB), 0);
    chk_all("flush");
    Flush = 0; Stall = 0;

    // Asynchronous reset between edges while a stall is holding a valid entry
    load(5, 5, 32'h55, 32'h5A);
    Stall = 1;
    EXMEM_Rd = 5; EXMEM_RegWrite = 1;
    #2;
    Rst = 1;
    m = bubble();
    #1;
    chk_all("async_rst");
    Rst = 0;
    Stall = 0; EXMEM_RegWrite = 0;
    tick();
    chk_all("post_rst");

    // Randomized traffic, small address space to provoke hazards
    for (int i = 0; i < 400; i++) begin
      Stall          = ($urandom_range(0, 9) < 3);
      Flush          = ($urandom_range(0, 9) == 0);
      ID_Valid       = $urandom_range(0, 1);
      ID_RegWrite    = $urandom_range(0, 1);
      ID_Rs          = AW'($urandom_range(0, 7));
      ID_Rt          = AW'($urandom_range(0, 7));
      ID_Rd          = AW'($urandom_range(0, 7));
      ID_RsData      = $urandom;
      ID_RtData      = $urandom;
      EXMEM_Rd       = AW'($urandom_range(0, 7));
      MEMWB_Rd       = AW'($urandom_range(0, 7));
      EXMEM_RegWrite = $urandom_range(0, 1);
      MEMWB_RegWrite = $urandom_range(0, 1);
      MEMWB_Data     = $urandom;
      #1;
      chk_all("rand_pre");
      tick();
      chk_all("rand_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_reg.md
ID_EX_FORWARD_REG -- requirements
Module: id_ex_forward_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports Stall, Flush  input  1 each  hold request / bubble-insert request.
REQ-006 SHALL have ports ID_RsData, ID_RtData  input  DATA_W each  register-file operands from decode.
REQ-007 SHALL have ports ID_Rs, ID_Rt, ID_Rd  input  REG_AW each  source and destination register addresses.
REQ-008 SHALL have ports ID_RegWrite, ID_Valid  input  1 each  writes-register flag / real-instruction flag.
REQ-009 SHALL have ports EXMEM_Rd, MEMWB_Rd  input  REG_AW each  destination registers of the two later stages.
REQ-010 SHALL have ports EXMEM_RegWrite, MEMWB_RegWrite  input  1 each  later-stage write enables.
REQ-011 SHALL have port MEMWB_Data  input  DATA_W  writeback value.
REQ-012 SHALL have ports EX_RsData, EX_RtData  output  DATA_W each  registered operands, feeding input A of the operand muxes.
REQ-013 SHALL have ports EX_Rs, EX_Rt, EX_Rd  output  REG_AW each; EX_RegWrite, EX_Valid  output  1 each  registered control.
REQ-014 SHALL have ports ForwardA, ForwardB  output  2 each  select codes for the Rs / Rt 3:1 operand muxes.

Function
REQ-015 SHALL, on a rising edge with Flush=0 and Stall=0, load all EX_* registers from the corresponding ID_* inputs (latency one cycle).
REQ-016 SHALL, on a rising edge with Flush=1, load a bubble: EX_Valid=0, EX_RegWrite=0, EX_Rs/Rt/Rd=0, EX_RsData/RtData=0; Flush SHALL take priority over Stall.
REQ-017 SHALL, on a rising edge with Stall=1 and Flush=0, hold all EX_* registers except as given by REQ-018.
REQ-018 SHALL, while stalled, replace EX_RsData (and independently EX_RtData) with MEMWB_Data when MEMWB_RegWrite=1, MEMWB_Rd equals EX_Rs (resp. EX_Rt), and that address is nonzero, so a retiring value is not lost during a multi-cycle stall.
REQ-019 SHALL drive ForwardA combinationally from registered EX_Rs: 2'b01 if EX_Valid, EXMEM_RegWrite, EXMEM_Rd!=0 and EXMEM_Rd==EX_Rs; else 2'b10 if EX_Valid, MEMWB_RegWrite, MEMWB_Rd!=0 and MEMWB_Rd==EX_Rs; else 2'b00.
REQ-020 SHALL drive ForwardB identically using EX_Rt.
REQ-021 SHALL give EX/MEM priority over MEM/WB when both match the same source.
REQ-022 SHALL never produce select code 2'b11.
REQ-023 SHALL never forward for register address 0 regardless of write enables.
REQ-024 SHALL output 2'b00 on both selects whenever EX_Valid=0.
REQ-025 SHALL give the same result with Stall and Flush asserted together as with Flush alone.

Reset
REQ-026 SHALL, while Rst=1, immediately and independently of Clk force all EX_* outputs to the bubble values of REQ-016, with ForwardA=ForwardB=2'b00.
REQ-027 SHALL, after Rst deasserts, capture on the first rising edge per REQ-015..REQ-018; reset asserted mid-stall discards held contents.

Structure
REQ-028 SHALL place the select encodings (SEL_REG=2'b00, SEL_EXMEM=2'b01, SEL_MEMWB=2'b10) and REG_AW in a shared package, also used by the operand-mux selection logic.
REQ-029 SHALL instantiate one sub-module, forward_select, twice (Rs and Rt) for the REQ-019 compare-and-priority logic; the pipeline registers SHALL be in the top module.

Verification
REQ-030 SHALL cover: ID_Rs=3, ID_RsData=0x11, no stall -> next cycle EX_Rs=3, EX_RsData=0x11, ForwardA=00.
REQ-031 SHALL cover: EX_Rs=4, EXMEM_Rd=4, MEMWB_Rd=4, both RegWrite=1 -> ForwardA=01; deassert EXMEM_RegWrite -> ForwardA=10.
REQ-032 SHALL cover: EX_Rt=0, EXMEM_Rd=0, EXMEM_RegWrite=1 -> ForwardB=00.
REQ-033 SHALL cover: Stall=1 for 3 cycles, EX_Rs=7, MEMWB_Rd=7, MEMWB_Data=0xDEAD, MEMWB_RegWrite=1 in cycle 2 -> EX_RsData=0xDEAD after cycle 2, other fields unchanged.
REQ-034 SHALL cover: Stall=1 and Flush=1 on the same edge -> EX_Valid=0, EX_RegWrite=0, ForwardA=ForwardB=00.
REQ-035 SHALL cover: Rst pulsed between clock edges with EX_Valid=1 -> outputs at bubble values before the next edge.
